// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity and prescale constants,
// and the bit-vote helper used by the receive sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  localparam int DATA_WIDTH_DEFAULT = 8;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Captures RX_IN at edge_cnt = P/2-1, P/2, P/2+1 and presents the 2-of-3 vote.
// The vote is stable from edge_cnt = P/2+2 until the next bit's first tap.
module uart_rx_data_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sampled_bit
);

  logic [PRESCALE_WIDTH-1:0] half;
  logic [2:0]                samples;

  assign half = prescale >> 1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tap
      logic [PRESCALE_WIDTH-1:0] tap;
      logic                      sample_reg;

      // Taps sit one edge either side of mid-bit.
      assign tap = half + PRESCALE_WIDTH'(gi) - PRESCALE_WIDTH'(1);

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          sample_reg <= 1'b0;
        end else if (edge_cnt == tap) begin
          sample_reg <= rx_in;
        end
      end

      assign samples[gi] = sample_reg;
    end
  endgenerate

  assign sampled_bit = majority3(samples);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled, majority-voted, LSB-first deserializer with
// optional parity and stop-bit checks; results are registered one-cycle pulses.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_t               state_reg;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_reg;
  logic [BIT_CNT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic [PRESCALE_WIDTH-1:0] prescale_reg;
  logic                      par_en_reg;
  logic                      par_typ_reg;
  logic                      par_mismatch_reg;

  logic sampled_bit;
  logic bit_end;
  logic par_expected;

  uart_rx_data_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .rx_in      (RX_IN),
    .edge_cnt   (edge_cnt_reg),
    .prescale   (prescale_reg),
    .sampled_bit(sampled_bit)
  );

  assign bit_end      = (edge_cnt_reg == prescale_reg - PRESCALE_WIDTH'(1));
  assign par_expected = (^shift_reg) ^ (par_typ_reg == PAR_ODD);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg        <= IDLE;
      edge_cnt_reg     <= '0;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      prescale_reg     <= '0;
      par_en_reg       <= 1'b0;
      par_typ_reg      <= 1'b0;
      par_mismatch_reg <= 1'b0;
      P_DATA           <= '0;
      data_valid       <= 1'b0;
      par_err          <= 1'b0;
      stp_err          <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state_reg != IDLE && state_reg != WAIT_HIGH) begin
        edge_cnt_reg <= bit_end ? '0 : edge_cnt_reg + PRESCALE_WIDTH'(1);
      end

      unique case (state_reg)
        IDLE: begin
          // The cycle that first sees the line low is edge 0 of the start bit.
          if (!RX_IN) begin
            state_reg        <= START;
            edge_cnt_reg     <= PRESCALE_WIDTH'(1);
            bit_cnt_reg      <= '0;
            par_mismatch_reg <= 1'b0;
            prescale_reg     <= Prescale;
            par_en_reg       <= PAR_EN;
            par_typ_reg      <= PAR_TYP;
          end
        end

        START: begin
          if (bit_end) begin
            state_reg <= sampled_bit ? IDLE : DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            if (bit_cnt_reg == BIT_CNT_W'(DATA_WIDTH - 1)) begin
              bit_cnt_reg <= '0;
              state_reg   <= par_en_reg ? PARITY : STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            par_mismatch_reg <= (sampled_bit != par_expected);
            state_reg        <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (!sampled_bit) begin
              stp_err   <= 1'b1;
              par_err   <= par_mismatch_reg;
              state_reg <= WAIT_HIGH;
            end else if (par_mismatch_reg) begin
              par_err   <= 1'b1;
              state_reg <= IDLE;
            end else begin
              P_DATA     <= shift_reg;
              data_valid <= 1'b1;
              state_reg  <= IDLE;
            end
          end
        end

        WAIT_HIGH: begin
          // A held-low or break line must return high before a new frame.
          if (RX_IN) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: a vector table of whole frames plus
// hand-written sequences for glitches, stuck-low line, back-to-back and reset.
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .DATA_WIDTH    (DW),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .RX_IN     (rx),
    .Prescale  (prescale),
    .PAR_EN    (par_en),
    .PAR_TYP   (par_typ),
    .P_DATA    (p_data),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  // Free-running posedge count and a negedge monitor of output pulses.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int            valid_total = 0;
  int            perr_total  = 0;
  int            serr_total  = 0;
  int            last_ev_cyc = 0;
  int            valid_cyc[64];
  logic [DW-1:0] valid_data[64];

  always @(negedge clk) begin
    if (data_valid || par_err || stp_err) last_ev_cyc = cyc;
    if (data_valid) begin
      if (valid_total < 64) begin
        valid_cyc[valid_total]  = cyc;
        valid_data[valid_total] = p_data;
      end
      valid_total++;
    end
    if (par_err) perr_total++;
    if (stp_err) serr_total++;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds one bit for p cycles; if glitch_at >= 0 the bit is inverted for the
  // single cycle that ends at the edge with edge_cnt == glitch_at.
  task automatic drive_bit(input logic b, input int p, input int glitch_at);
    for (int k = 0; k < p; k++) begin
      rx = (k == glitch_at) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            input int glitch_bit);
    prescale = PW'(p);
    par_en   = pen;
    par_typ  = ptyp;
    drive_bit(1'b0, p, -1);
    for (int i = 0; i < DW; i++) drive_bit(d[i], p, (i == glitch_bit) ? p / 2 : -1);
    if (pen) drive_bit(pbit, p, -1);
    drive_bit(sbit, p, -1);
  endtask

  typedef struct {
    int            p;
    logic          pen;
    logic          ptyp;
    logic [DW-1:0] d;
    logic          pbit;
    logic          sbit;
    int            exp_valid;
    int            exp_perr;
    int            exp_serr;
    logic [DW-1:0] exp_pdata;
  } vec_t;

  vec_t vecs[7];

  int v0, p0, s0, start_cyc;

  task automatic snap();
    v0 = valid_total;
    p0 = perr_total;
    s0 = serr_total;
  endtask

  initial begin
    // 0x37 has five ones (even parity bit 1); 0x5A has four (odd parity bit 1);
    // 0x0F has four, so a parity bit of 1 is an even-parity mismatch.
    vecs[0] = '{8,  1'b0, PAR_EVEN, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
    vecs[1] = '{16, 1'b1, PAR_EVEN, 8'h37, 1'b1, 1'b1, 1, 0, 0, 8'h37};
    vecs[2] = '{16, 1'b1, PAR_EVEN, 8'h37, 1'b0, 1'b1, 0, 1, 0, 8'h37};
    vecs[3] = '{8,  1'b1, PAR_ODD,  8'h5A, 1'b1, 1'b1, 1, 0, 0, 8'h5A};
    vecs[4] = '{32, 1'b0, PAR_EVEN, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
    vecs[5] = '{8,  1'b0, PAR_EVEN, 8'h12, 1'b0, 1'b0, 0, 0, 1, 8'hFF};
    vecs[6] = '{8,  1'b1, PAR_EVEN, 8'h0F, 1'b1, 1'b0, 0, 1, 1, 8'hFF};

    // Reset state
    tick(3);
    check("reset P_DATA", int'(p_data), 0);
    check("reset data_valid", int'(data_valid), 0);
    check("reset par_err", int'(par_err), 0);
    check("reset stp_err", int'(stp_err), 0);
    check("reset state", int'(dut.state_reg), int'(IDLE));
    rst_n = 1'b1;
    tick(3);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      snap();
      start_cyc = cyc;
      send_frame(vecs[i].d, vecs[i].p, vecs[i].pen, vecs[i].ptyp, vecs[i].pbit, vecs[i].sbit, -1);
      rx = 1'b1;
      tick(4);
      $display("vec %0d: P=%0d pen=%0d data=%02h -> valid=%0d perr=%0d serr=%0d P_DATA=%02h",
               i, vecs[i].p, vecs[i].pen, vecs[i].d, valid_total - v0, perr_total - p0,
               serr_total - s0, p_data);
      check($sformatf("vec%0d valid", i), valid_total - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d par_err", i), perr_total - p0, vecs[i].exp_perr);
      check($sformatf("vec%0d stp_err", i), serr_total - s0, vecs[i].exp_serr);
      check($sformatf("vec%0d P_DATA", i), int'(p_data), int'(vecs[i].exp_pdata));
      check($sformatf("vec%0d latency", i), last_ev_cyc - start_cyc,
            (10 + int'(vecs[i].pen)) * vecs[i].p);
    end

    // Stop bit low, line then held low: one stp_err, stuck in WAIT_HIGH
    snap();
    start_cyc = cyc;
    send_frame(8'h00, 32, 1'b1, PAR_ODD, 1'b1, 1'b0, -1);
    tick(100);
    $display("stuck-low: serr=%0d valid=%0d perr=%0d", serr_total - s0, valid_total - v0, perr_total - p0);
    check("stuck stp_err count", serr_total - s0, 1);
    check("stuck valid count", valid_total - v0, 0);
    check("stuck par_err count", perr_total - p0, 0);
    check("stuck latency", last_ev_cyc - start_cyc, 11 * 32);
    check("stuck state", int'(dut.state_reg), int'(WAIT_HIGH));
    rx = 1'b1;
    tick(4);
    check("released state", int'(dut.state_reg), int'(IDLE));
    snap();
    send_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    rx = 1'b1;
    tick(4);
    $display("after release: valid=%0d P_DATA=%02h", valid_total - v0, p_data);
    check("after release valid", valid_total - v0, 1);
    check("after release P_DATA", int'(p_data), 8'h81);

    // Two-cycle start glitch
    snap();
    prescale = PW'(16);
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(40);
    $display("start glitch: pulses=%0d", (valid_total - v0) + (perr_total - p0) + (serr_total - s0));
    check("start glitch pulses", (valid_total - v0) + (perr_total - p0) + (serr_total - s0), 0);
    check("start glitch state", int'(dut.state_reg), int'(IDLE));

    // One-cycle glitch at mid-bit of data bit 3
    snap();
    send_frame(8'h6B, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3);
    rx = 1'b1;
    tick(4);
    $display("data glitch: valid=%0d P_DATA=%02h", valid_total - v0, p_data);
    check("data glitch valid", valid_total - v0, 1);
    check("data glitch P_DATA", int'(p_data), 8'h6B);
    check("data glitch errors", (perr_total - p0) + (serr_total - s0), 0);

    // Back-to-back frames with no idle between them
    snap();
    send_frame(8'h55, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    send_frame(8'hAA, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    rx = 1'b1;
    tick(4);
    $display("back-to-back: valid=%0d", valid_total - v0);
    check("b2b valid count", valid_total - v0, 2);
    check("b2b first data", int'(valid_data[v0]), 8'h55);
    check("b2b second data", int'(valid_data[v0 + 1]), 8'hAA);
    check("b2b spacing", valid_cyc[v0 + 1] - valid_cyc[v0], 80);

    // Reset in the middle of the data bits of 0x3C
    snap();
    prescale = PW'(8);
    par_en = 1'b0;
    drive_bit(1'b0, 8, -1);
    drive_bit(1'b0, 8, -1);
    drive_bit(1'b0, 8, -1);
    drive_bit(1'b1, 8, -1);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("midreset P_DATA", int'(p_data), 0);
    check("midreset state", int'(dut.state_reg), int'(IDLE));
    tick(2);
    rst_n = 1'b1;
    tick(4);
    send_frame(8'hC3, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    rx = 1'b1;
    tick(4);
    $display("after reset: valid=%0d P_DATA=%02h", valid_total - v0, p_data);
    check("midreset valid count", valid_total - v0, 1);
    check("midreset P_DATA after", int'(p_data), 8'hC3);
    check("midreset errors", (perr_total - p0) + (serr_total - s0), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive path: the counterpart of the UART TX serializer, on the same frame format. Oversamples RX_IN at a programmable prescale and majority-votes each bit. Shifts the data in LSB-first, optionally checks parity, checks the stop bit, and presents a parallel byte with a one-cycle valid pulse. Sits between the synchronized RX pin and the register/system controller in the RX clock domain.

Parameters:
DATA_WIDTH, 8, data bits per frame.
PRESCALE_WIDTH, 6, width of Prescale input (supports 8, 16, 32).

Ports:
CLK  input  1  oversampling clock (Prescale x baud).
RST  input  1  asynchronous reset, active-low.
RX_IN  input  1  serial line, already synchronized; idle high.
Prescale  input  PRESCALE_WIDTH  CLK cycles per bit; legal 8/16/32.
PAR_EN  input  1  1 = parity bit present after data.
PAR_TYP  input  1  0 = even, 1 = odd.
P_DATA  output  DATA_WIDTH  last good received byte.
data_valid  output  1  one-cycle pulse, P_DATA updated.
par_err  output  1  one-cycle pulse, parity mismatch.
stp_err  output  1  one-cycle pulse, stop bit sampled 0.

Behaviour:
- Reset values: P_DATA=0, data_valid=0, par_err=0, stp_err=0, FSM=IDLE, counters=0, shift register=0.
- Reset mid-frame: all outputs and state clear immediately; the partial frame is discarded.
- Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1).
- edge_cnt counts 0..Prescale-1 within a bit and wraps to 0 at Prescale-1. bit_cnt counts data bits.
- Prescale, PAR_EN and PAR_TYP are latched when leaving IDLE and stay fixed for the frame. Illegal Prescale values are undefined.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, valid from edge_cnt = P/2+2.
- States:
  - IDLE: RX_IN=0 at a clock edge -> START, edge_cnt<=1 (that cycle counts as edge 0).
  - START: at edge_cnt=P-1, majority=0 -> DATA. Majority=1 (glitch) -> IDLE, no output pulses.
  - DATA: at each edge_cnt=P-1, shift the majority bit into the MSB and shift right, so the first bit lands at bit 0. After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: at edge_cnt=P-1, compare the majority with XOR(data) (even) or ~XOR(data) (odd); store the mismatch flag -> STOP.
  - STOP: at edge_cnt=P-1, evaluate and go to the next state (see priority below).
  - WAIT_HIGH: stay until RX_IN=1, then -> IDLE. Prevents a stuck-low or break line from generating repeated frames.
- Output priority at the end of STOP, outputs registered (visible in the next cycle):
  - stop=0: stp_err=1 (and par_err=1 if a mismatch was stored), data_valid=0, P_DATA unchanged -> WAIT_HIGH.
  - stop=1 with parity mismatch: par_err=1, data_valid=0, P_DATA unchanged -> IDLE.
  - otherwise: P_DATA<=shift register, data_valid=1 -> IDLE.
- Back-to-back frames: IDLE accepts a start one cycle after STOP completes. The minimum frame gap is one CLK cycle.
- Latency: data_valid rises 1 CLK after the last edge of the stop bit. Measured from the start falling edge, that is (1+DATA_WIDTH+PAR_EN+1)*P cycles, +1 registered cycle.
- Pulses last exactly one cycle. P_DATA holds its value between valid pulses.
- RX_IN changes outside the sample window are ignored.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding, shared with the TX FSM style.
  - Parity type constants PAR_EVEN=0 and PAR_ODD=1.
  - Legal prescale constants 8/16/32.
  - DATA_WIDTH default.
- One sub-module: uart_rx_data_sampler. It holds the three sample flops and the majority logic, driven by edge_cnt and Prescale, and outputs sampled_bit.
- The FSM, counters, shifter and parity/stop checks stay in the top module.

Test Plan:
- Prescale=8, PAR_EN=0: send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> data_valid pulse, P_DATA=0xA5, no errors, 80 cycles from start edge + 1.
- Prescale=16, PAR_EN=1, PAR_TYP=0: send 0x37 with even parity bit 1 -> P_DATA=0x37, data_valid=1. Repeat with parity bit 0 -> par_err pulse, data_valid=0, P_DATA stays 0x37.
- Prescale=32, PAR_EN=1, PAR_TYP=1: send 0x00, odd parity 1, stop=0, line then held low 100 cycles -> single stp_err pulse, FSM remains in WAIT_HIGH until RX_IN=1, no second frame.
- Start glitch: RX_IN low for 2 cycles at Prescale=16 -> returns to IDLE, no pulses. A 1-cycle glitch in mid data sample window (edge P/2) -> majority rejects it, byte received correctly.
- Back-to-back: two frames 0x55, 0xAA separated by zero idle bits, Prescale=8 -> two data_valid pulses 80 cycles apart with correct data.
- Assert RST low during DATA of frame 0x3C, release, send 0xC3 -> no pulse for the aborted frame, P_DATA=0xC3 with one data_valid.
